param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO. It is the successor to the team's fixed 8-bit FIFO and keeps the same `buf_in`/`buf_out`/`wr_en`/`rd_en`/`buf_empty`/`buf_full`/`fifo_counter` port semantics. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between any producer and consumer sharing one clock, and is the standard buffering element for datapath blocks.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 26 ++
 rtl/param_sync_fifo.sv | 131 +++++++++++++
 tb/tb_param_sync_fifo.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the parametrised FIFO.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // Occupancy counter width: one extra bit so a full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
// Optional macro FIFO_FWFT_EN: first-word-fall-through read data
// (head word shown combinationally); otherwise buf_out is a registered read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = cnt_w(DEPTH),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              clr_err,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  fifo_counter,
    output logic              overflow,
    output logic              underflow
);

    // Reject illegal configurations at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH) && (AE_LEVEL >= 0))) begin : g_bad_levels
        $error("param_sync_fifo: require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("param_sync_fifo: DATA_W must be >= 1");
    end

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_udf;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_rd_acc;
    logic              w_wr_acc;

    // Status flags decode the registered count only.
    assign buf_empty    = (r_count == '0);
    assign buf_full     = (r_count == CNT_W'(DEPTH));
    assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));
    assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
    assign fifo_counter = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

    // A full FIFO can still take a write when a read frees a slot in the same cycle.
    assign w_rd_ok  = rd_en & ~buf_empty;
    assign w_wr_ok  = wr_en & (~buf_full | w_rd_ok);
    // Flush swallows any request in its cycle.
    assign w_rd_acc = w_rd_ok & ~flush;
    assign w_wr_acc = w_wr_ok & ~flush;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (buf_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear, flush raises none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (~flush & wr_en & ~w_wr_ok) r_ovf <= 1'b1;
            else if (clr_err)              r_ovf <= 1'b0;
            if (~flush & rd_en & ~w_rd_ok) r_udf <= 1'b1;
            else if (clr_err)              r_udf <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; zero while empty.
    assign buf_out = buf_empty ? '0 : w_rd_data;
`else
    logic [DATA_W-1:0] r_dout;

    // Registered read: capture the head on an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_dout <= '0;
        else if (w_rd_acc) r_dout <= w_rd_data;
    end

    assign buf_out = r_dout;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo at default parameters (DATA_W=8, DEPTH=16).
module tb_param_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush, clr_err, wr_en, rd_en;
    logic [DATA_W-1:0] buf_in;
    logic [DATA_W-1:0] buf_out;
    logic              buf_empty, buf_full, almost_empty, almost_full;
    logic [CNT_W-1:0]  fifo_counter;
    logic              overflow, underflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] q[$];

    param_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .clr_err      (clr_err),
        .wr_en        (wr_en),
        .buf_in       (buf_in),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_counter (fifo_counter),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; clr_err = 0; wr_en = 0; rd_en = 0; buf_in = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++;
        if ({buf_empty, almost_empty, buf_full, almost_full, overflow, underflow} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags: got e/ae/f/af/ov/un=%b expected 110000",
                     {buf_empty, almost_empty, buf_full, almost_full, overflow, underflow});
        end
        checks++;
        if (fifo_counter !== 0 || buf_out !== 0) begin
            errors++;
            $display("FAIL reset_data: got count=%0d out=%h expected 0/00", fifo_counter, buf_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; buf_in = DATA_W'(i); q.push_back(DATA_W'(i));
            step();
            checks++;
            if (fifo_counter !== CNT_W'(i + 1) || almost_full !== (i + 1 >= 14) || buf_full !== (i + 1 == DEPTH)) begin
                errors++;
                $display("FAIL fill_%0d: got count=%0d af=%b full=%b expected count=%0d af=%b full=%b",
                         i, fifo_counter, almost_full, buf_full, i + 1, (i + 1 >= 14), (i + 1 == DEPTH));
            end
        end
        wr_en = 0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] exp;
        wr_en = 1; buf_in = 8'hAA;
        step();
        wr_en = 0;
        checks++;
        if (fifo_counter !== CNT_W'(16) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got count=%0d ovf=%b expected 16/1", fifo_counter, overflow);
        end
        clr_err = 1;
        step();
        clr_err = 0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        rd_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = q.pop_front();
`ifdef FIFO_FWFT_EN
            checks++;
            if (buf_out !== exp) begin
                errors++;
                $display("FAIL ovf_drain_%0d: got %h expected %h", i, buf_out, exp);
            end
`endif
            step();
`ifndef FIFO_FWFT_EN
            checks++;
            if (buf_out !== exp) begin
                errors++;
                $display("FAIL ovf_drain_%0d: got %h expected %h", i, buf_out, exp);
            end
`endif
        end
        rd_en = 0;
        checks++;
        if (buf_empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: got %b expected 1", buf_empty);
        end
    endtask

    task automatic test_underflow();
        logic [DATA_W-1:0] exp_out;
`ifdef FIFO_FWFT_EN
        exp_out = 8'h00;
`else
        exp_out = 8'h0F;
`endif
        rd_en = 1;
        step();
        rd_en = 0;
        checks++;
        if (underflow !== 1'b1 || fifo_counter !== 0 || buf_out !== exp_out) begin
            errors++;
            $display("FAIL underflow: got un=%b count=%0d out=%h expected 1/0/%h",
                     underflow, fifo_counter, buf_out, exp_out);
        end
        clr_err = 1;
        step();
        clr_err = 0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b expected 0", underflow);
        end
    endtask

    task automatic test_simultaneous();
        logic [DATA_W-1:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; buf_in = DATA_W'(100 + i); q.push_back(DATA_W'(100 + i));
            step();
        end
        // Full: the write rides on the accepted read.
        wr_en = 1; rd_en = 1; buf_in = 8'h55;
        exp = q.pop_front();
`ifdef FIFO_FWFT_EN
        checks++;
        if (buf_out !== exp) begin
            errors++;
            $display("FAIL simul_head: got %h expected %h", buf_out, exp);
        end
`endif
        step();
        q.push_back(8'h55);
        wr_en = 0;
`ifndef FIFO_FWFT_EN
        checks++;
        if (buf_out !== exp) begin
            errors++;
            $display("FAIL simul_head: got %h expected %h", buf_out, exp);
        end
`endif
        checks++;
        if (fifo_counter !== CNT_W'(16) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_count: got count=%0d ovf=%b expected 16/0", fifo_counter, overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = q.pop_front();
`ifdef FIFO_FWFT_EN
            checks++;
            if (buf_out !== exp) begin
                errors++;
                $display("FAIL simul_drain_%0d: got %h expected %h", i, buf_out, exp);
            end
`endif
            step();
`ifndef FIFO_FWFT_EN
            checks++;
            if (buf_out !== exp) begin
                errors++;
                $display("FAIL simul_drain_%0d: got %h expected %h", i, buf_out, exp);
            end
`endif
        end
        rd_en = 0;
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] exp;
        logic              rd;
        int                reads = 0;
        for (int c = 0; c < 60 && reads < 40; c++) begin
            rd = (c >= 3) && (q.size() > 0);
            rd_en = rd;
            wr_en = (c < 40);
            buf_in = DATA_W'(c);
            exp = '0;
            if (rd) begin
                exp = q.pop_front();
                reads++;
`ifdef FIFO_FWFT_EN
                checks++;
                if (buf_out !== exp) begin
                    errors++;
                    $display("FAIL wrap_rd_%0d: got %h expected %h", reads - 1, buf_out, exp);
                end
`endif
            end
            if (c < 40) q.push_back(DATA_W'(c));
            step();
`ifndef FIFO_FWFT_EN
            if (rd) begin
                checks++;
                if (buf_out !== exp) begin
                    errors++;
                    $display("FAIL wrap_rd_%0d: got %h expected %h", reads - 1, buf_out, exp);
                end
            end
`endif
            checks++;
            if (fifo_counter !== CNT_W'(q.size()) || fifo_counter > 4) begin
                errors++;
                $display("FAIL wrap_count_%0d: got %0d expected %0d (max 4)", c, fifo_counter, q.size());
            end
        end
        rd_en = 0; wr_en = 0;
        checks++;
        if (reads !== 40 || buf_empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got reads=%0d empty=%b expected 40/1", reads, buf_empty);
        end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] exp_out;
`ifdef FIFO_FWFT_EN
        exp_out = 8'h00;
`else
        exp_out = 8'd39;
`endif
        rd_en = 1;            // leaves underflow set across the flush
        step();
        rd_en = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; buf_in = DATA_W'(8'h10 + i);
            step();
        end
        flush = 1; wr_en = 1; rd_en = 1; buf_in = 8'hEE;
        step();
        flush = 0; wr_en = 0; rd_en = 0;
        q.delete();
        checks++;
        if (fifo_counter !== 0 || buf_empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_count: got count=%0d empty=%b expected 0/1", fifo_counter, buf_empty);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b1 || buf_out !== exp_out) begin
            errors++;
            $display("FAIL flush_keep: got ovf=%b un=%b out=%h expected 0/1/%h",
                     overflow, underflow, buf_out, exp_out);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; buf_in = DATA_W'(8'h20 + i);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({buf_empty, almost_empty, buf_full, almost_full, overflow, underflow} !== 6'b110000 ||
            fifo_counter !== 0 || buf_out !== 0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b count=%0d out=%h expected 110000/0/00",
                     {buf_empty, almost_empty, buf_full, almost_full, overflow, underflow},
                     fifo_counter, buf_out);
        end
        wr_en = 0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_first_word();
        logic [DATA_W-1:0] exp_out;
`ifdef FIFO_FWFT_EN
        exp_out = 8'h3C;
`else
        exp_out = 8'h00;
`endif
        wr_en = 1; buf_in = 8'h3C;
        step();
        wr_en = 0;
        checks++;
        if (buf_empty !== 1'b0 || buf_out !== exp_out) begin
            errors++;
            $display("FAIL first_word: got empty=%b out=%h expected 0/%h", buf_empty, buf_out, exp_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        test_flush();
        test_async_reset();
        test_first_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
